// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - in-order instruction FIFO feeding the two oldest entries to the IDU
module instruction_queue #(
  parameter int DEPTH   = 8,
  parameter int FIELD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     IQ_in_valid,
  output logic                     IQ_in_ready,
  input  logic [FIELD_W-1:0]       IQ_in_type,
  input  logic [FIELD_W-1:0]       IQ_in_destination_reg,
  input  logic [FIELD_W-1:0]       IQ_in_source_reg1,
  input  logic [FIELD_W-1:0]       IQ_in_source_reg2,
  output logic                     IQ_out_inst1_valid,
  output logic [FIELD_W-1:0]       IQ_out_inst1_type,
  output logic [FIELD_W-1:0]       IQ_out_inst1_destination_reg1,
  output logic [FIELD_W-1:0]       IQ_out_inst1_source_reg1,
  output logic [FIELD_W-1:0]       IQ_out_inst1_source_reg2,
  output logic                     IQ_out_inst2_valid,
  output logic [FIELD_W-1:0]       IQ_out_inst2_type,
  output logic [FIELD_W-1:0]       IQ_out_inst2_destination_reg2,
  output logic [FIELD_W-1:0]       IQ_out_inst2_source_reg3,
  output logic [FIELD_W-1:0]       IQ_out_inst2_source_reg4,
  input  logic [1:0]               select_instruction,
  output logic [$clog2(DEPTH):0]   IQ_count,
  output logic                     IQ_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 * FIELD_W;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail, head_next1;
  logic [CW-1:0] count;
  logic          err;
  logic          push, illegal;
  logic          v1, v2;
  logic [1:0]    ack, pop;
  logic [EW-1:0] e1, e2;

  // Ready depends only on registered occupancy, never on this cycle's acknowledge.
  assign IQ_in_ready = (count != CW'(DEPTH));
  assign push        = IQ_in_valid && IQ_in_ready;
  assign v1          = (count != '0);
  assign v2          = (count > CW'(1));
  assign head_next1  = head + 1'b1;

  // Acknowledge bits for empty slots are dropped before decoding.
  always_comb begin
    pop     = 2'd0;
    illegal = 1'b0;
    ack     = select_instruction & {v2, v1};
    case (ack)
      2'b01:   pop = 2'd1;
      2'b11:   pop = 2'd2;
      2'b10:   illegal = 1'b1;
      default: pop = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      head  <= head + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
      if (illegal) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[tail] <= {IQ_in_type, IQ_in_destination_reg, IQ_in_source_reg1, IQ_in_source_reg2};
  end

  assign e1 = v1 ? mem[head]       : '0;
  assign e2 = v2 ? mem[head_next1] : '0;

  assign IQ_out_inst1_valid            = v1;
  assign IQ_out_inst1_type             = e1[4*FIELD_W-1:3*FIELD_W];
  assign IQ_out_inst1_destination_reg1 = e1[3*FIELD_W-1:2*FIELD_W];
  assign IQ_out_inst1_source_reg1      = e1[2*FIELD_W-1:FIELD_W];
  assign IQ_out_inst1_source_reg2      = e1[FIELD_W-1:0];
  assign IQ_out_inst2_valid            = v2;
  assign IQ_out_inst2_type             = e2[4*FIELD_W-1:3*FIELD_W];
  assign IQ_out_inst2_destination_reg2 = e2[3*FIELD_W-1:2*FIELD_W];
  assign IQ_out_inst2_source_reg3      = e2[2*FIELD_W-1:FIELD_W];
  assign IQ_out_inst2_source_reg4      = e2[FIELD_W-1:0];
  assign IQ_count                      = count;
  assign IQ_err                        = err;

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - scoreboard bench for instruction_queue
module tb_instruction_queue;

  localparam int DEPTH = 8;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_MUL = 8'h02;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_type = '0, in_dst = '0, in_s1 = '0, in_s2 = '0;
  logic [1:0] sel = 2'b00;
  logic in_ready, v1, v2, err;
  logic [7:0] t1, d1, a1, b1, t2, d2, a2, b2;
  logic [3:0] count;

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];
  bit model_err = 1'b0;

  always #5 clk = ~clk;

  instruction_queue #(.DEPTH(DEPTH), .FIELD_W(8)) dut (
    .clk(clk), .rst(rst),
    .IQ_in_valid(in_valid), .IQ_in_ready(in_ready),
    .IQ_in_type(in_type), .IQ_in_destination_reg(in_dst),
    .IQ_in_source_reg1(in_s1), .IQ_in_source_reg2(in_s2),
    .IQ_out_inst1_valid(v1), .IQ_out_inst1_type(t1),
    .IQ_out_inst1_destination_reg1(d1), .IQ_out_inst1_source_reg1(a1),
    .IQ_out_inst1_source_reg2(b1),
    .IQ_out_inst2_valid(v2), .IQ_out_inst2_type(t2),
    .IQ_out_inst2_destination_reg2(d2), .IQ_out_inst2_source_reg3(a2),
    .IQ_out_inst2_source_reg4(b2),
    .select_instruction(sel), .IQ_count(count), .IQ_err(err)
  );

  wire [32:0] obs1 = {v1, t1, d1, a1, b1};
  wire [32:0] obs2 = {v2, t2, d2, a2, b2};

  function automatic logic [32:0] exp_slot(input int i);
    if (sb.size() > i) return {1'b1, sb[i]};
    return 33'd0;
  endfunction

  // One clock: drive, update the reference queue at the edge, settle past the edge.
  task automatic cycle(input bit r, input bit v, input logic [31:0] e, input logic [1:0] s);
    int n;
    int npop;
    rst = r; in_valid = v; sel = s;
    {in_type, in_dst, in_s1, in_s2} = e;
    n = sb.size();
    @(posedge clk);
    if (r) begin
      sb.delete();
      model_err = 1'b0;
    end else begin
      npop = 0;
      case (s)
        2'b01: npop = (n >= 1) ? 1 : 0;
        2'b11: npop = (n >= 2) ? 2 : n;
        2'b10: if (n >= 2) model_err = 1'b1;
        default: npop = 0;
      endcase
      for (int k = 0; k < npop; k++) void'(sb.pop_front());
      if (v && n < DEPTH) sb.push_back(e);
    end
    #1;
    rst = 1'b0; in_valid = 1'b0; sel = 2'b00;
  endtask

  task automatic test_reset();
    cycle(1, 0, 32'h0, 2'b00);
    cycle(1, 0, 32'h0, 2'b00);
    cycle(0, 0, 32'h0, 2'b00);
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got %0d exp 0", count); end
    total++; if (obs1 !== 33'd0) begin bad++; $display("FAIL reset_inst1 got %h exp 0", obs1); end
    total++; if (obs2 !== 33'd0) begin bad++; $display("FAIL reset_inst2 got %h exp 0", obs2); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_push_two();
    cycle(0, 1, {OP_MUL, 8'd2, 8'd0, 8'd1}, 2'b00);
    total++; if (obs1 !== {1'b1, OP_MUL, 8'd2, 8'd0, 8'd1}) begin bad++; $display("FAIL push1_inst1 got %h exp %h", obs1, {1'b1, OP_MUL, 8'd2, 8'd0, 8'd1}); end
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL push1_inst2_valid got %b exp 0", v2); end
    cycle(0, 1, {OP_ADD, 8'd5, 8'd3, 8'd4}, 2'b00);
    total++; if (obs2 !== {1'b1, OP_ADD, 8'd5, 8'd3, 8'd4}) begin bad++; $display("FAIL push2_inst2 got %h exp %h", obs2, {1'b1, OP_ADD, 8'd5, 8'd3, 8'd4}); end
    total++; if (count !== 4'd2) begin bad++; $display("FAIL push2_count got %0d exp 2", count); end
    cycle(0, 0, 32'h0, 2'b11);
    total++; if (count !== 4'(sb.size())) begin bad++; $display("FAIL push2_drain got %0d exp %0d", count, sb.size()); end
  endtask

  task automatic test_dual_dispatch();
    for (int i = 1; i <= 4; i++) cycle(0, 1, {OP_ADD, 8'(i), 8'(i + 16), 8'(i + 32)}, 2'b00);
    total++; if (count !== 4'd4) begin bad++; $display("FAIL dual_fill got %0d exp 4", count); end
    cycle(0, 0, 32'h0, 2'b11);
    total++; if (count !== 4'd2) begin bad++; $display("FAIL dual_count got %0d exp 2", count); end
    total++; if (obs1 !== {1'b1, OP_ADD, 8'd3, 8'd19, 8'd35}) begin bad++; $display("FAIL dual_inst1 got %h exp %h", obs1, {1'b1, OP_ADD, 8'd3, 8'd19, 8'd35}); end
    total++; if (obs2 !== {1'b1, OP_ADD, 8'd4, 8'd20, 8'd36}) begin bad++; $display("FAIL dual_inst2 got %h exp %h", obs2, {1'b1, OP_ADD, 8'd4, 8'd20, 8'd36}); end
    cycle(0, 0, 32'h0, 2'b11);
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, {OP_MUL, 8'(8'h40 + i), 8'(i), 8'(i + 1)}, 2'b00);
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count got %0d exp 8", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %b exp 0", in_ready); end
    cycle(0, 1, {OP_ADD, 8'hEE, 8'hEE, 8'hEE}, 2'b00);
    total++; if (count !== 4'd8) begin bad++; $display("FAIL full_drop_count got %0d exp 8", count); end
    total++; if (obs1 !== exp_slot(0)) begin bad++; $display("FAIL full_drop_inst1 got %h exp %h", obs1, exp_slot(0)); end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, {OP_ADD, 8'(8'h80 + i), 8'(i * 3), 8'(i * 5)}, 2'b01);
      total++; if (obs1 !== exp_slot(0)) begin bad++; $display("FAIL wrap_inst1[%0d] got %h exp %h", i, obs1, exp_slot(0)); end
      total++; if (obs2 !== exp_slot(1)) begin bad++; $display("FAIL wrap_inst2[%0d] got %h exp %h", i, obs2, exp_slot(1)); end
      total++; if (count !== 4'(sb.size())) begin bad++; $display("FAIL wrap_count[%0d] got %0d exp %0d", i, count, sb.size()); end
    end
    for (int i = 0; i < DEPTH && sb.size() > 0; i++) begin
      cycle(0, 0, 32'h0, 2'b11);
      total++; if (obs1 !== exp_slot(0)) begin bad++; $display("FAIL drain_inst1[%0d] got %h exp %h", i, obs1, exp_slot(0)); end
    end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL drain_count got %0d exp 0", count); end
  endtask

  task automatic test_clamp_illegal();
    cycle(0, 1, {OP_MUL, 8'd7, 8'd6, 8'd5}, 2'b00);
    cycle(0, 0, 32'h0, 2'b11);
    total++; if (count !== 4'd0) begin bad++; $display("FAIL clamp_count got %0d exp 0", count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL clamp_err got %b exp 0", err); end
    cycle(0, 0, 32'h0, 2'b01);
    total++; if (count !== 4'd0) begin bad++; $display("FAIL empty_pop_count got %0d exp 0", count); end
    cycle(0, 1, {OP_ADD, 8'd1, 8'd2, 8'd3}, 2'b00);
    cycle(0, 1, {OP_ADD, 8'd4, 8'd5, 8'd6}, 2'b00);
    cycle(0, 0, 32'h0, 2'b10);
    total++; if (count !== 4'd2) begin bad++; $display("FAIL illegal_count got %0d exp 2", count); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got %b exp 1", err); end
    total++; if (obs1 !== exp_slot(0)) begin bad++; $display("FAIL illegal_inst1 got %h exp %h", obs1, exp_slot(0)); end
    cycle(0, 0, 32'h0, 2'b00);
    total++; if (err !== model_err) begin bad++; $display("FAIL sticky_err got %b exp %b", err, model_err); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(0, 1, {OP_MUL, 8'(i), 8'(i), 8'(i)}, 2'b00);
    total++; if (count !== 4'd5) begin bad++; $display("FAIL mid_fill got %0d exp 5", count); end
    cycle(1, 1, {OP_ADD, 8'hAA, 8'hBB, 8'hCC}, 2'b01);
    total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_rst_count got %0d exp 0", count); end
    total++; if ({v1, v2} !== 2'b00) begin bad++; $display("FAIL mid_rst_valids got %b exp 00", {v1, v2}); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got %b exp 0", err); end
    total++; if (obs1 !== 33'd0) begin bad++; $display("FAIL mid_rst_inst1 got %h exp 0", obs1); end
    cycle(0, 1, {OP_ADD, 8'd9, 8'd8, 8'd7}, 2'b11);
    total++; if (obs1 !== {1'b1, OP_ADD, 8'd9, 8'd8, 8'd7}) begin bad++; $display("FAIL post_rst_inst1 got %h exp %h", obs1, {1'b1, OP_ADD, 8'd9, 8'd8, 8'd7}); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL post_rst_count got %0d exp 1", count); end
    cycle(0, 1, {OP_MUL, 8'd3, 8'd2, 8'd1}, 2'b11);
    total++; if (obs1 !== {1'b1, OP_MUL, 8'd3, 8'd2, 8'd1}) begin bad++; $display("FAIL push_pop2_inst1 got %h exp %h", obs1, {1'b1, OP_MUL, 8'd3, 8'd2, 8'd1}); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL push_pop2_count got %0d exp 1", count); end
  endtask

  initial begin
    test_reset();
    test_push_two();
    test_dual_dispatch();
    test_full_wrap();
    test_clamp_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
